// File: rtl/mem_refill_responder.sv
// Next-level memory model behind the cache miss path: block refills and writebacks with programmable latency.
// Optional build macro CRITICAL_WORD_FIRST_EN: read bursts start at the addressed beat and wrap.
module mem_refill_responder #(
  parameter int unsigned ADDR_W            = 24,
  parameter int unsigned BLOCK_OFFSET_BITS = 3,
  parameter int unsigned DATA_W            = 8,
  parameter int unsigned MEM_DEPTH_BITS    = 10,
  parameter int unsigned LATENCY           = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last,
  output logic              busy,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count
);

  localparam int unsigned BEATS    = ((2 ** BLOCK_OFFSET_BITS) * 8) / DATA_W;
  localparam int unsigned BEAT_W   = $clog2(BEATS);
  localparam int unsigned LANE_W   = $clog2(DATA_W / 8);
  localparam int unsigned BASE_W   = MEM_DEPTH_BITS - BEAT_W;
  localparam int unsigned MEM_SIZE = 2 ** MEM_DEPTH_BITS;
  localparam int unsigned CNT_W    = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [CNT_W-1:0]  LAT_LOAD  = CNT_W'(LATENCY);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WR_DATA  = 3'd1;
  localparam logic [2:0] S_WAIT     = 3'd2;
  localparam logic [2:0] S_RD_BURST = 3'd3;
  localparam logic [2:0] S_WR_ACK   = 3'd4;

  logic [DATA_W-1:0] mem [MEM_SIZE];

  logic [2:0]        state_q, state_n;
  logic              write_q, write_n;
  logic [BASE_W-1:0] base_q, base_n;
  logic [BEAT_W-1:0] beat_q, beat_n;
  logic [BEAT_W-1:0] xfer_q, xfer_n;
  logic [CNT_W-1:0]  cnt_q, cnt_n;

  logic              req_ready_n, wr_ready_n, rsp_valid_n, rsp_last_n, busy_n;
  logic [DATA_W-1:0] rsp_data_n;
  logic [15:0]       rd_count_n, wr_count_n;

  logic                      mem_we_c;
  logic [MEM_DEPTH_BITS-1:0] mem_wr_idx_c;
  logic [MEM_DEPTH_BITS-1:0] mem_rd_idx_c;
  logic [BASE_W-1:0]         req_base_c;
  logic [BEAT_W-1:0]         req_beat_c;
  logic                      unused_addr_c;

  assign req_base_c    = req_addr[MEM_DEPTH_BITS+LANE_W-1:BLOCK_OFFSET_BITS];
  assign req_beat_c    = req_addr[BLOCK_OFFSET_BITS-1:LANE_W];
  // Upper bits alias by design; byte-lane bits never select a beat.
  assign unused_addr_c = ^{req_addr[ADDR_W-1:MEM_DEPTH_BITS+LANE_W], req_addr[BLOCK_OFFSET_BITS-1:0]};

  // Next-state, datapath and registered-output values
  always_comb begin
    state_n      = state_q;
    write_n      = write_q;
    base_n       = base_q;
    beat_n       = beat_q;
    xfer_n       = xfer_q;
    cnt_n        = cnt_q;
    rd_count_n   = rd_count;
    wr_count_n   = wr_count;
    mem_we_c     = 1'b0;
    mem_wr_idx_c = {base_q, beat_q};

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          write_n = req_write;
          base_n  = req_base_c;
          beat_n  = '0;
          xfer_n  = '0;
          if (req_write) begin
            state_n = S_WR_DATA;
          end else begin
`ifdef CRITICAL_WORD_FIRST_EN
            beat_n = req_beat_c;
`endif
            cnt_n   = LAT_LOAD;
            state_n = (LATENCY == 0) ? S_RD_BURST : S_WAIT;
          end
        end
      end
      S_WR_DATA: begin
        if (wr_valid) begin
          mem_we_c = 1'b1;
          beat_n   = beat_q + BEAT_W'(1);
          if (beat_q == LAST_BEAT) begin
            cnt_n   = LAT_LOAD;
            state_n = (LATENCY == 0) ? S_WR_ACK : S_WAIT;
          end
        end
      end
      S_WAIT: begin
        // Count was loaded with LATENCY on entry; leave as it reaches zero.
        if (cnt_q <= CNT_W'(1)) begin
          cnt_n   = '0;
          state_n = write_q ? S_WR_ACK : S_RD_BURST;
        end else begin
          cnt_n = cnt_q - CNT_W'(1);
        end
      end
      S_RD_BURST: begin
        if (rsp_ready) begin
          beat_n = beat_q + BEAT_W'(1);
          xfer_n = xfer_q + BEAT_W'(1);
          if (xfer_q == LAST_BEAT) begin
            rd_count_n = rd_count + 16'd1;
            state_n    = S_IDLE;
          end
        end
      end
      S_WR_ACK: begin
        if (rsp_ready) begin
          wr_count_n = wr_count + 16'd1;
          state_n    = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase

    // Outputs follow the next state so they are valid straight after the edge
    mem_rd_idx_c = {base_n, beat_n};
    req_ready_n  = (state_n == S_IDLE);
    wr_ready_n   = (state_n == S_WR_DATA);
    busy_n       = (state_n != S_IDLE);
    rsp_valid_n  = (state_n == S_RD_BURST) || (state_n == S_WR_ACK);
    rsp_last_n   = 1'b0;
    rsp_data_n   = '0;
    if (state_n == S_RD_BURST) begin
      rsp_data_n = mem[mem_rd_idx_c];
      rsp_last_n = (xfer_n == LAST_BEAT);
    end else if (state_n == S_WR_ACK) begin
      rsp_last_n = 1'b1;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      write_q   <= 1'b0;
      base_q    <= '0;
      beat_q    <= '0;
      xfer_q    <= '0;
      cnt_q     <= '0;
      req_ready <= 1'b1;
      wr_ready  <= 1'b0;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_last  <= 1'b0;
      rsp_data  <= '0;
      rd_count  <= '0;
      wr_count  <= '0;
    end else begin
      state_q   <= state_n;
      write_q   <= write_n;
      base_q    <= base_n;
      beat_q    <= beat_n;
      xfer_q    <= xfer_n;
      cnt_q     <= cnt_n;
      req_ready <= req_ready_n;
      wr_ready  <= wr_ready_n;
      busy      <= busy_n;
      rsp_valid <= rsp_valid_n;
      rsp_last  <= rsp_last_n;
      rsp_data  <= rsp_data_n;
      rd_count  <= rd_count_n;
      wr_count  <= wr_count_n;
    end
  end

  // Backing storage is deliberately not reset
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem[mem_wr_idx_c] <= wr_data;
    end
  end

endmodule

// File: tb/tb_mem_refill_responder.sv
// Directed bench for mem_refill_responder: default-latency instance plus a LATENCY=0 instance.
module tb_mem_refill_responder;

  logic        clk = 1'b0;
  logic        rst_n_a, rst_n_b;
  logic        sel;
  logic        req_valid, req_write, wr_valid, rsp_ready;
  logic [23:0] req_addr;
  logic [7:0]  wr_data;

  logic        req_ready_a, wr_ready_a, rsp_valid_a, rsp_last_a, busy_a;
  logic [7:0]  rsp_data_a;
  logic [15:0] rd_count_a, wr_count_a;
  logic        req_ready_b, wr_ready_b, rsp_valid_b, rsp_last_b, busy_b;
  logic [7:0]  rsp_data_b;
  logic [15:0] rd_count_b, wr_count_b;

  logic        req_ready, wr_ready, rsp_valid, rsp_last, busy;
  logic [7:0]  rsp_data;
  logic [15:0] rd_count, wr_count;

  int checks = 0;
  int errors = 0;
  logic [7:0] got_data [8];
  logic       got_last [8];
  int         got_n;
  int         got_lat;

  always #5 clk = ~clk;

  mem_refill_responder u_dut_a (
    .clk(clk), .rst_n(rst_n_a), .req_valid(req_valid), .req_ready(req_ready_a),
    .req_write(req_write), .req_addr(req_addr), .wr_valid(wr_valid), .wr_ready(wr_ready_a),
    .wr_data(wr_data), .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready), .rsp_data(rsp_data_a),
    .rsp_last(rsp_last_a), .busy(busy_a), .rd_count(rd_count_a), .wr_count(wr_count_a)
  );

  mem_refill_responder #(.LATENCY(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n_b), .req_valid(req_valid), .req_ready(req_ready_b),
    .req_write(req_write), .req_addr(req_addr), .wr_valid(wr_valid), .wr_ready(wr_ready_b),
    .wr_data(wr_data), .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready), .rsp_data(rsp_data_b),
    .rsp_last(rsp_last_b), .busy(busy_b), .rd_count(rd_count_b), .wr_count(wr_count_b)
  );

  assign req_ready = sel ? req_ready_b : req_ready_a;
  assign wr_ready  = sel ? wr_ready_b  : wr_ready_a;
  assign rsp_valid = sel ? rsp_valid_b : rsp_valid_a;
  assign rsp_last  = sel ? rsp_last_b  : rsp_last_a;
  assign rsp_data  = sel ? rsp_data_b  : rsp_data_a;
  assign busy      = sel ? busy_b      : busy_a;
  assign rd_count  = sel ? rd_count_b  : rd_count_a;
  assign wr_count  = sel ? wr_count_b  : wr_count_a;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Returns at the falling edge just after the request handshake edge
  task automatic send_req(input logic w, input logic [23:0] a);
    int n;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("req_accept", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic write_beats(input logic [7:0] first);
    int n;
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wr_valid = 1'b1;
      wr_data  = first + 8'(i);
      n = 0;
      while (!wr_ready && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (!wr_ready) ok = 1'b0;
      @(negedge clk);
    end
    wr_valid = 1'b0;
    chk("write_beats_accepted", 32'(ok), 32'd1);
  endtask

  task automatic wait_ack();
    int n;
    rsp_ready = 1'b1;
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ack_valid", 32'(rsp_valid), 32'd1);
    chk("ack_data", 32'(rsp_data), 32'd0);
    chk("ack_last", 32'(rsp_last), 32'd1);
    @(negedge clk);
    chk("ack_done_busy", 32'(busy), 32'd0);
  endtask

  // Gathers up to 'stop' beats, driving rsp_ready from a repeating 4-cycle pattern
  task automatic collect(input logic [3:0] pat, input int stop);
    int cyc;
    logic held;
    logic [7:0] hd;
    logic hl;
    logic [1:0] idx;
    got_n   = 0;
    got_lat = 1;
    held    = 1'b0;
    hd      = '0;
    hl      = 1'b0;
    while (!rsp_valid && got_lat < 50) begin
      @(negedge clk);
      got_lat++;
    end
    cyc = 0;
    while (got_n < stop && cyc < 100) begin
      chk("burst_valid", 32'(rsp_valid), 32'd1);
      if (held) begin
        chk("stall_data", 32'(rsp_data), 32'(hd));
        chk("stall_last", 32'(rsp_last), 32'(hl));
      end
      idx = 2'(cyc);
      rsp_ready = pat[idx];
      if (rsp_ready) begin
        got_data[got_n] = rsp_data;
        got_last[got_n] = rsp_last;
        got_n++;
        held = 1'b0;
      end else begin
        held = 1'b1;
        hd   = rsp_data;
        hl   = rsp_last;
      end
      cyc++;
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    chk("beats_collected", 32'(got_n), 32'(stop));
  endtask

  task automatic expect_beats(input string tag, input logic [7:0] first, input int rot);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("%s_beat%0d_data", tag, i), 32'(got_data[i]), 32'(first + 8'((rot + i) % 8)));
      chk($sformatf("%s_beat%0d_last", tag, i), 32'(got_last[i]), 32'(i == 7));
    end
  endtask

  initial begin
    sel       = 1'b0;
    rst_n_a   = 1'b0;
    rst_n_b   = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    wr_valid  = 1'b0;
    wr_data   = '0;
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);

    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_last", 32'(rsp_last), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_wr_ready", 32'(wr_ready), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rd_count", 32'(rd_count), 32'd0);
    chk("rst_wr_count", 32'(wr_count), 32'd0);
    rst_n_a = 1'b1;
    @(negedge clk);

    // Writeback of block 0x40 then a plain refill
    send_req(1'b1, 24'h000040);
    chk("wr_busy", 32'(busy), 32'd1);
    chk("wr_req_ready", 32'(req_ready), 32'd0);
    chk("wr_wr_ready", 32'(wr_ready), 32'd1);
    write_beats(8'h10);
    wait_ack();
    chk("wr_count_1", 32'(wr_count), 32'd1);

    send_req(1'b0, 24'h000040);
    collect(4'b1111, 8);
    chk("rd_latency", 32'(got_lat), 32'd5);
    expect_beats("rd", 8'h10, 0);
    chk("rd_count_1", 32'(rd_count), 32'd1);
    chk("rd_idle_busy", 32'(busy), 32'd0);

    // Backpressure with rsp_ready 1,0,0,1
    send_req(1'b0, 24'h000040);
    collect(4'b1001, 8);
    expect_beats("bp", 8'h10, 0);
    chk("rd_count_2", 32'(rd_count), 32'd2);

    // Offset address: critical word first only in the macro build
    send_req(1'b0, 24'h000045);
    collect(4'b1111, 8);
`ifdef CRITICAL_WORD_FIRST_EN
    expect_beats("cwf", 8'h10, 5);
`else
    expect_beats("cwf", 8'h10, 0);
`endif
    chk("rd_count_3", 32'(rd_count), 32'd3);

    // Stray wr_valid and a held req_valid must be ignored
    wr_valid = 1'b1;
    wr_data  = 8'hEE;
    repeat (3) @(negedge clk);
    send_req(1'b0, 24'h000040);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 24'h000080;
    chk("held_req_ready", 32'(req_ready), 32'd0);
    collect(4'b1111, 8);
    req_valid = 1'b0;
    wr_valid  = 1'b0;
    expect_beats("ign", 8'h10, 0);
    chk("rd_count_4", 32'(rd_count), 32'd4);
    @(negedge clk);
    chk("ign_busy", 32'(busy), 32'd0);
    chk("ign_wr_count", 32'(wr_count), 32'd1);

    // Reset after the third beat abandons the burst
    send_req(1'b0, 24'h000040);
    collect(4'b1111, 3);
    chk("part_beat2", 32'(got_data[2]), 32'h12);
    rst_n_a = 1'b0;
    #1;
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_req_ready", 32'(req_ready), 32'd1);
    chk("midrst_rd_count", 32'(rd_count), 32'd0);
    @(negedge clk);
    rst_n_a = 1'b1;
    @(negedge clk);
    send_req(1'b0, 24'h000040);
    collect(4'b1111, 8);
    expect_beats("post_rst", 8'h10, 0);
    chk("post_rst_rd_count", 32'(rd_count), 32'd1);

    // LATENCY=0 instance with address aliasing
    rst_n_a = 1'b0;
    sel     = 1'b1;
    rst_n_b = 1'b1;
    @(negedge clk);
    send_req(1'b1, 24'h000000);
    write_beats(8'hA0);
    wait_ack();
    send_req(1'b0, 24'h002000);
    collect(4'b1111, 8);
    chk("lat0_latency", 32'(got_lat), 32'd1);
    expect_beats("alias", 8'hA0, 0);
    chk("lat0_rd_count", 32'(rd_count), 32'd1);
    chk("lat0_wr_count", 32'(wr_count), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
